// File: rtl/nbody_step_scheduler.sv
// nbody_step_scheduler: walks every ordered body pair (i,j), i!=j, into the
// force pipeline, waits for all results to retire, integrates each body once,
// and repeats for GAP timesteps before raising done for the host snapshot.
// Optional feature macro: NBODY_SCHED_PERF_EN (busy-cycle counter on perf_cycles).
module nbody_step_scheduler #(
    parameter int BODY_ADDR_WIDTH = 9,
    parameter int GAP_WIDTH       = 32,
    parameter int OUTST_WIDTH     = 8,
    parameter int PIPE_LATENCY    = 122
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       go,
    input  logic [BODY_ADDR_WIDTH:0]   n_bodies,
    input  logic [GAP_WIDTH-1:0]       gap,
    input  logic                       snap_req,
    input  logic                       pipe_ready,
    input  logic                       pipe_ret,
    output logic                       pair_valid,
    output logic [BODY_ADDR_WIDTH-1:0] pair_i,
    output logic [BODY_ADDR_WIDTH-1:0] pair_j,
    output logic                       pair_first,
    output logic                       pair_last,
    output logic                       upd_valid,
    input  logic                       upd_ready,
    output logic [BODY_ADDR_WIDTH-1:0] upd_addr,
    output logic                       done,
    output logic                       busy,
    output logic                       err,
    output logic [31:0]                perf_cycles
);

    localparam int NW = BODY_ADDR_WIDTH + 1;
    localparam logic [NW-1:0] MAX_N = {1'b1, {BODY_ADDR_WIDTH{1'b0}}};

    // The in-flight counter must be able to hold a full pipeline of pairs.
    if (PIPE_LATENCY > (2 ** OUTST_WIDTH) - 1) begin : g_latency_check
        $error("OUTST_WIDTH too narrow for PIPE_LATENCY");
    end

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, UPDATE, STEP, FRAME} state_t;

    state_t                     state, next_state;
    logic [BODY_ADDR_WIDTH-1:0] i_reg, j_reg, upd_cnt;
    logic [NW-1:0]              n_reg;
    logic [GAP_WIDTH-1:0]       gap_reg, step_cnt;
    logic [OUTST_WIDTH-1:0]     outstanding;
    logic                       seen, err_reg;

    logic [NW-1:0] i_ext, j_ext, j_inc, j_skip, n_m1, n_m2, upd_ext;
    logic          n_ok, first_flag, last_flag, issue, upd_fire;
    logic          step_last, frame_exit, last_pair, start_pass;

    assign i_ext      = {1'b0, i_reg};
    assign j_ext      = {1'b0, j_reg};
    assign upd_ext    = {1'b0, upd_cnt};
    assign n_m1       = n_reg - NW'(1);
    assign n_m2       = n_reg - NW'(2);
    assign j_inc      = j_ext + NW'(1);
    assign j_skip     = (j_inc == i_ext) ? j_inc + NW'(1) : j_inc;
    assign n_ok       = (n_bodies >= NW'(2)) && (n_bodies <= MAX_N);
    assign first_flag = (i_reg == '0) ? (j_ext == NW'(1)) : (j_reg == '0);
    assign last_flag  = (i_ext == n_m1) ? (j_ext == n_m2) : (j_ext == n_m1);
    assign last_pair  = (i_ext == n_m1) && last_flag;
    assign issue      = pair_valid && pipe_ready;
    assign upd_fire   = upd_valid && upd_ready;
    assign step_last  = (step_cnt + GAP_WIDTH'(1)) == gap_reg;
    assign frame_exit = (state == FRAME) && seen && !snap_req;
    assign start_pass = (next_state == ISSUE) && (state != ISSUE);

    assign pair_valid = (state == ISSUE);
    assign pair_i     = i_reg;
    assign pair_j     = j_reg;
    assign pair_first = pair_valid && first_flag;
    assign pair_last  = pair_valid && last_flag;
    assign upd_valid  = (state == UPDATE);
    assign upd_addr   = upd_cnt;
    assign done       = (state == FRAME);
    assign busy       = (state != IDLE);
    assign err        = err_reg;

    // State register; reset forces an immediate return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode for the issue/drain/update/step/frame sequence.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (go && n_ok) next_state = ISSUE;
            ISSUE:   if (issue && last_pair) next_state = DRAIN;
            DRAIN:   if (outstanding == '0) next_state = UPDATE;
            UPDATE:  if (upd_fire && (upd_ext == n_m1)) next_state = STEP;
            STEP:    next_state = step_last ? FRAME : ISSUE;
            FRAME:   if (frame_exit) next_state = go ? ISSUE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pair walker, in-flight count, update address, step count and handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_reg       <= '0;
            j_reg       <= '0;
            n_reg       <= '0;
            gap_reg     <= '0;
            step_cnt    <= '0;
            outstanding <= '0;
            upd_cnt     <= '0;
            seen        <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            if (state == IDLE && go && !n_ok) err_reg <= 1'b1;
            if (state == IDLE && go && n_ok) begin
                n_reg   <= n_bodies;
                gap_reg <= (gap == '0) ? GAP_WIDTH'(1) : gap;
            end

            if (start_pass) begin
                i_reg <= '0;
                j_reg <= BODY_ADDR_WIDTH'(1);
            end else if (issue) begin
                if (j_skip >= n_reg) begin
                    i_reg <= i_reg + BODY_ADDR_WIDTH'(1);
                    j_reg <= '0;
                end else begin
                    j_reg <= j_skip[BODY_ADDR_WIDTH-1:0];
                end
            end

            if (issue && !pipe_ret)
                outstanding <= outstanding + OUTST_WIDTH'(1);
            else if (!issue && pipe_ret && outstanding != '0)
                outstanding <= outstanding - OUTST_WIDTH'(1);

            if (state == DRAIN)  upd_cnt <= '0;
            else if (upd_fire)   upd_cnt <= upd_cnt + BODY_ADDR_WIDTH'(1);

            if (state == STEP)
                step_cnt <= step_last ? '0 : step_cnt + GAP_WIDTH'(1);

            if (frame_exit)                       seen <= 1'b0;
            else if (state == FRAME && snap_req)  seen <= 1'b1;
        end
    end

`ifdef NBODY_SCHED_PERF_EN
    logic [31:0] perf_reg;
    // Busy-cycle counter: cleared at start, frozen in FRAME, saturating.
    always_ff @(posedge clk) begin
        if (rst)
            perf_reg <= '0;
        else if (state == IDLE && next_state == ISSUE)
            perf_reg <= '0;
        else if (busy && state != FRAME && perf_reg != 32'hFFFF_FFFF)
            perf_reg <= perf_reg + 32'd1;
    end
    assign perf_cycles = perf_reg;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_nbody_step_scheduler.sv
// tb_nbody_step_scheduler: directed bench for the nbody pair/update scheduler.
// Builds with or without NBODY_SCHED_PERF_EN; the perf expectation follows the macro.
module tb_nbody_step_scheduler;

    logic        clk = 1'b0;
    logic        rst, go, snap_req, pipe_ready, pipe_ret, upd_ready;
    logic [9:0]  n_bodies;
    logic [31:0] gap;
    logic        pair_valid, pair_first, pair_last, upd_valid, done, busy, err;
    logic [8:0]  pair_i, pair_j, upd_addr;
    logic [31:0] perf_cycles;

    int total = 0;
    int passed = 0;
    int fails = 0;
    int cyc = 0;
    int busy_model = 0;
    int ret_q[$];

    nbody_step_scheduler dut (
        .clk(clk), .rst(rst), .go(go), .n_bodies(n_bodies), .gap(gap),
        .snap_req(snap_req), .pipe_ready(pipe_ready), .pipe_ret(pipe_ret),
        .pair_valid(pair_valid), .pair_i(pair_i), .pair_j(pair_j),
        .pair_first(pair_first), .pair_last(pair_last),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr),
        .done(done), .busy(busy), .err(err), .perf_cycles(perf_cycles)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the busy model counts non-FRAME busy cycles.
    task automatic applyStimulus();
        if (busy === 1'b1 && done === 1'b0) busy_model++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] allOutputs();
        return {31'd0, pair_valid, pair_i, pair_j, pair_first, pair_last,
                upd_valid, upd_addr, done, busy};
    endfunction

    task automatic checkPerf(input string tag);
`ifdef NBODY_SCHED_PERF_EN
        checkOutput(tag, 64'(perf_cycles), 64'(busy_model));
`else
        checkOutput(tag, 64'(perf_cycles), 64'd0);
`endif
    endtask

    // Run from the first ISSUE cycle to FRAME with a fixed-latency return model.
    task automatic runFrame(input int n, input int g, input int lat, input bit toggle, input int budget);
        int k = 0;
        int upds = 0;
        int np = n * (n - 1);
        bit held = 0;
        logic [18:0] held_val = '0;
        ret_q.delete();
        for (int c = 0; c < budget; c++) begin
            if (done === 1'b1) break;
            pipe_ready = toggle ? (c % 2 == 0) : 1'b1;
            upd_ready  = 1'b1;
            pipe_ret   = 1'b0;
            if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
                pipe_ret = 1'b1;
                void'(ret_q.pop_front());
            end
            if (held) checkOutput("pair_held_stable", 64'({pair_valid, pair_i, pair_j}), 64'(held_val));
            held = 0;
            if (pair_valid === 1'b1) begin
                if (pipe_ready) begin
                    int kk = k % np;
                    int ei = kk / (n - 1);
                    int r  = kk % (n - 1);
                    int ej = (r < ei) ? r : r + 1;
                    checkOutput("pair_order",
                                64'({pair_i, pair_j, pair_first, pair_last}),
                                64'({9'(ei), 9'(ej), r == 0, r == n - 2}));
                    ret_q.push_back(cyc + lat);
                    k++;
                end else begin
                    held = 1;
                    held_val = {1'b1, pair_i, pair_j};
                end
            end
            if (upd_valid === 1'b1 && upd_ready) begin
                checkOutput("upd_addr", 64'(upd_addr), 64'(upds % n));
                upds++;
            end
            applyStimulus();
        end
        pipe_ret = 1'b0;
        pipe_ready = 1'b1;
        checkOutput("frame_done", 64'(done), 64'd1);
        checkOutput("issue_count", 64'(k), 64'(g * np));
        checkOutput("update_count", 64'(upds), 64'(g * n));
        checkPerf("perf_cycles");
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; snap_req = 1'b0; pipe_ready = 1'b1; pipe_ret = 1'b0;
        upd_ready = 1'b1; n_bodies = 10'd0; gap = 32'd0;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_outputs", allOutputs(), 64'd0);
        checkOutput("reset_err", 64'(err), 64'd0);
        checkOutput("reset_perf", 64'(perf_cycles), 64'd0);
        rst = 1'b0;
        applyStimulus();

        $display("[TB] n=3 gap=1, ready high, 3-cycle return");
        n_bodies = 10'd3; gap = 32'd1; go = 1'b1; busy_model = 0;
        applyStimulus();
        checkOutput("first_valid_latency", 64'({pair_valid, pair_i, pair_j}), 64'({1'b1, 9'd0, 9'd1}));
        runFrame(3, 1, 3, 1'b0, 200);
        snap_req = 1'b1;
        applyStimulus();
        checkOutput("done_held_in_snap", 64'(done), 64'd1);
        snap_req = 1'b0;
        applyStimulus();
        checkOutput("frame_exit_go1", 64'({done, pair_valid, pair_i, pair_j}),
                    64'({1'b0, 1'b1, 9'd0, 9'd1}));

        $display("[TB] n=3 gap=1 again, pipe_ready toggling");
        runFrame(3, 1, 3, 1'b1, 300);
        go = 1'b0;
        snap_req = 1'b1;
        applyStimulus();
        snap_req = 1'b0;
        applyStimulus();
        checkOutput("frame_exit_go0", 64'({busy, done, pair_valid}), 64'd0);

        $display("[TB] n=25 gap=6, 122-cycle return, inputs changed mid-run");
        n_bodies = 10'd25; gap = 32'd6; go = 1'b1; busy_model = 0;
        applyStimulus();
        gap = 32'd1; n_bodies = 10'd4; go = 1'b0;
        runFrame(25, 6, 122, 1'b0, 8000);
        snap_req = 1'b1;
        applyStimulus();
        snap_req = 1'b0;
        applyStimulus();
        checkOutput("idle_after_big", 64'(busy), 64'd0);

        $display("[TB] n=2 gap=0, manual returns, same-cycle issue/return");
        pipe_ret = 1'b1;
        applyStimulus();
        pipe_ret = 1'b0;
        n_bodies = 10'd2; gap = 32'd0; go = 1'b1;
        applyStimulus();
        go = 1'b0;
        checkOutput("n2_pair0", 64'({pair_valid, pair_i, pair_j, pair_first, pair_last}),
                    64'({1'b1, 9'd0, 9'd1, 1'b1, 1'b1}));
        applyStimulus();
        checkOutput("n2_pair1", 64'({pair_valid, pair_i, pair_j, pair_first, pair_last}),
                    64'({1'b1, 9'd1, 9'd0, 1'b1, 1'b1}));
        pipe_ret = 1'b1;
        applyStimulus();
        pipe_ret = 1'b0;
        checkOutput("n2_drain_entry", 64'({pair_valid, busy}), 64'({1'b0, 1'b1}));
        for (int w = 0; w < 3; w++) applyStimulus();
        checkOutput("n2_drain_wait", 64'(upd_valid), 64'd0);
        pipe_ret = 1'b1;
        applyStimulus();
        pipe_ret = 1'b0;
        checkOutput("n2_drain_last_ret", 64'(upd_valid), 64'd0);
        applyStimulus();
        checkOutput("n2_update0", 64'({upd_valid, upd_addr}), 64'({1'b1, 9'd0}));
        upd_ready = 1'b0;
        applyStimulus();
        checkOutput("n2_update_hold", 64'({upd_valid, upd_addr}), 64'({1'b1, 9'd0}));
        upd_ready = 1'b1;
        applyStimulus();
        checkOutput("n2_update1", 64'({upd_valid, upd_addr}), 64'({1'b1, 9'd1}));
        applyStimulus();
        checkOutput("n2_step", 64'({upd_valid, done, busy}), 64'({1'b0, 1'b0, 1'b1}));
        applyStimulus();
        checkOutput("n2_gap0_frame", 64'(done), 64'd1);
        snap_req = 1'b1;
        applyStimulus();
        snap_req = 1'b0;
        applyStimulus();
        checkOutput("n2_idle", 64'(busy), 64'd0);

        $display("[TB] reset mid-ISSUE");
        n_bodies = 10'd4; gap = 32'd1; go = 1'b1;
        applyStimulus();
        go = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("pre_reset_issue", 64'(pair_valid), 64'd1);
        rst = 1'b1;
        applyStimulus();
        checkOutput("mid_reset_outputs", allOutputs(), 64'd0);
        checkOutput("mid_reset_perf", 64'(perf_cycles), 64'd0);
        rst = 1'b0;

        $display("[TB] bad body counts and err");
        n_bodies = 10'd513; go = 1'b1;
        applyStimulus();
        go = 1'b0;
        applyStimulus();
        checkOutput("err_n513", 64'({err, busy, pair_valid}), 64'({1'b1, 1'b0, 1'b0}));
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("err_cleared", 64'(err), 64'd0);
        n_bodies = 10'd1; go = 1'b1;
        applyStimulus();
        go = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("err_n1", 64'({err, busy, pair_valid}), 64'({1'b1, 1'b0, 1'b0}));
        n_bodies = 10'd512; go = 1'b1;
        applyStimulus();
        go = 1'b0;
        checkOutput("n512_accepted", 64'({err, busy, pair_valid, pair_i, pair_j}),
                    64'({1'b1, 1'b1, 1'b1, 9'd0, 9'd1}));
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("final_reset", 64'({err, busy}), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
